// File: rtl/otter_prog_loader.sv
// Serial program loader: receives a length-prefixed, XOR-checksummed byte image
// and writes it word by word into memory port 2 while holding the CPU in reset.
module otter_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic [1:0]  MEM_SIZE2,
    output logic        CPU_RESET,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4,
        FAIL  = 3'd5
    } state_t;

    localparam logic [31:0] MAX_W      = 32'(MAX_WORDS);
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word_cnt;
    logic [31:0] r_len;
    logic [31:0] r_shift;
    logic [7:0]  r_csum;
    logic [31:0] r_idle;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic        r_mem_write;
    logic        r_cpu_reset;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_word;
    logic [31:0] w_word_next;
    logic        w_timeout;

    // Incoming byte lands in the top lane, so four shifts give a little-endian word.
    assign w_word      = {RX_DATA, r_shift[31:8]};
    assign w_word_next = r_word_cnt + 32'd1;
    assign w_timeout   = (r_idle == TIMEOUT_M1);

    assign MEM_ADDR2  = r_mem_addr;
    assign MEM_DIN2   = r_mem_din;
    assign MEM_WRITE2 = r_mem_write;
    assign MEM_SIZE2  = 2'b10;
    assign CPU_RESET  = r_cpu_reset;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ERR        = r_err;

    // Loader FSM with all datapath registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= 32'd0;
            r_len       <= 32'd0;
            r_shift     <= 32'd0;
            r_csum      <= 8'd0;
            r_idle      <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_din   <= 32'd0;
            r_mem_write <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_write <= 1'b0;
            case (r_state)
                IDLE, FIN, FAIL: begin
                    if (START) begin
                        r_state     <= LEN;
                        r_busy      <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_byte_cnt  <= 2'd0;
                        r_word_cnt  <= 32'd0;
                        r_csum      <= 8'd0;
                        r_idle      <= 32'd0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                LEN: begin
                    if (RX_VALID) begin
                        r_idle     <= 32'd0;
                        r_shift    <= w_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_len <= w_word;
                            if (w_word > MAX_W) begin
                                r_state <= FAIL;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else if (w_word == 32'd0) begin
                                r_state <= CHECK;
                            end else begin
                                r_state <= DATA;
                            end
                        end else begin
                            r_state <= LEN;
                        end
                    end else if (w_timeout) begin
                        r_state <= FAIL;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                DATA: begin
                    if (RX_VALID) begin
                        r_idle     <= 32'd0;
                        r_shift    <= w_word;
                        r_csum     <= r_csum ^ RX_DATA;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_write <= 1'b1;
                            r_mem_din   <= w_word;
                            r_mem_addr  <= BASE_ADDR + (r_word_cnt << 2);
                            r_word_cnt  <= w_word_next;
                            if (w_word_next == r_len) begin
                                r_state <= CHECK;
                            end else begin
                                r_state <= DATA;
                            end
                        end else begin
                            r_state <= DATA;
                        end
                    end else if (w_timeout) begin
                        r_state <= FAIL;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                CHECK: begin
                    if (RX_VALID) begin
                        r_idle <= 32'd0;
                        r_busy <= 1'b0;
                        if (RX_DATA == r_csum) begin
                            r_state     <= FIN;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            // Words already written stay in memory; the CPU is just kept in reset.
                            r_state <= FAIL;
                            r_err   <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= FAIL;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_cpu_reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_prog_loader.sv
// Directed self-checking bench for otter_prog_loader (TIMEOUT shortened to 50).
module tb_otter_prog_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic [1:0]  MEM_SIZE2;
    logic        CPU_RESET;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int base_wr = 0;

    otter_prog_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (16384),
        .TIMEOUT   (50)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .MEM_ADDR2  (MEM_ADDR2),
        .MEM_DIN2   (MEM_DIN2),
        .MEM_WRITE2 (MEM_WRITE2),
        .MEM_SIZE2  (MEM_SIZE2),
        .CPU_RESET  (CPU_RESET),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    // Count write strobes, sampled mid-cycle.
    always @(negedge CLK) begin
        if (MEM_WRITE2 === 1'b1) n_wr <= n_wr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8]);
            if (gap && i < 3) tick();
        end
    endtask

    task automatic start_load();
        START = 1'b1;
        tick();
        START = 1'b0;
        base_wr = n_wr;
    endtask

    initial begin
        RESET = 1'b1; START = 1'b1; RX_VALID = 1'b1; RX_DATA = 8'hFF;
        repeat (3) tick();
        chk("rst_write", {31'd0, MEM_WRITE2}, 32'd0);
        chk("rst_addr",  MEM_ADDR2, 32'd0);
        chk("rst_din",   MEM_DIN2, 32'd0);
        chk("rst_flags", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'd0);
        chk("size",      {30'd0, MEM_SIZE2}, 32'd2);
        RESET = 1'b0; START = 1'b0; RX_VALID = 1'b0;
        tick();
        chk("idle_busy", {31'd0, BUSY}, 32'd0);

        // Nominal, back-to-back bytes
        start_load();
        chk("nom_busy", {30'd0, BUSY, CPU_RESET}, 32'd3);
        send4(32'h0000_0002, 1'b0);
        send4(32'h0000_0013, 1'b0);
        chk("nom_w0_strobe", {31'd0, MEM_WRITE2}, 32'd1);
        chk("nom_w0_addr", MEM_ADDR2, 32'h0000_0000);
        chk("nom_w0_din",  MEM_DIN2, 32'h0000_0013);
        send(8'h6F);
        chk("nom_one_cycle", {31'd0, MEM_WRITE2}, 32'd0);
        send(8'h00); send(8'h00); send(8'h00);
        chk("nom_w1_strobe", {31'd0, MEM_WRITE2}, 32'd1);
        chk("nom_w1_addr", MEM_ADDR2, 32'h0000_0004);
        chk("nom_w1_din",  MEM_DIN2, 32'h0000_006F);
        send(8'h7C);
        chk("nom_flags", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b0100);
        tick();
        chk("nom_nwr", 32'(n_wr - base_wr), 32'd2);

        // Bad checksum with gaps, START ignored mid-load
        start_load();
        send4(32'h0000_0002, 1'b1);
        tick();
        send(8'h13);
        RX_DATA = 8'h00; RX_VALID = 1'b1; START = 1'b1;
        tick();
        START = 1'b0; RX_VALID = 1'b0;
        send(8'h00); tick(); send(8'h00);
        chk("bad_w0_din", MEM_DIN2, 32'h0000_0013);
        tick();
        send4(32'h0000_006F, 1'b1);
        chk("bad_w1_addr", MEM_ADDR2, 32'h0000_0004);
        chk("bad_w1_din",  MEM_DIN2, 32'h0000_006F);
        tick();
        send(8'h00);
        chk("bad_flags", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b0011);
        tick();
        chk("bad_nwr", 32'(n_wr - base_wr), 32'd2);

        // Oversize length, then bytes in FAIL are ignored
        start_load();
        send4(32'h0000_4001, 1'b0);
        chk("big_flags", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b0011);
        send4(32'h1111_1111, 1'b0);
        send(8'h00);
        tick();
        chk("big_nwr", 32'(n_wr - base_wr), 32'd0);
        chk("big_flags2", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b0011);

        // Empty image
        start_load();
        send4(32'h0000_0000, 1'b0);
        chk("empty_busy", {31'd0, BUSY}, 32'd1);
        send(8'h00);
        tick();
        chk("empty_flags", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b0100);
        chk("empty_nwr", 32'(n_wr - base_wr), 32'd0);

        // N == MAX_WORDS accepted, then RESET alongside a word-completing byte
        start_load();
        send4(32'h0000_4000, 1'b0);
        chk("max_flags", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b1001);
        send4(32'h4433_2211, 1'b0);
        chk("max_w0_addr", MEM_ADDR2, 32'h0000_0000);
        chk("max_w0_din",  MEM_DIN2, 32'h4433_2211);
        send(8'h55); send(8'h66); send(8'h77);
        RX_DATA = 8'h88; RX_VALID = 1'b1; RESET = 1'b1; START = 1'b1;
        tick();
        RX_VALID = 1'b0; RESET = 1'b0; START = 1'b0;
        chk("mid_rst_write", {31'd0, MEM_WRITE2}, 32'd0);
        chk("mid_rst_addr",  MEM_ADDR2, 32'd0);
        chk("mid_rst_din",   MEM_DIN2, 32'd0);
        chk("mid_rst_flags", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'd0);
        send4(32'hDEAD_BEEF, 1'b0);
        repeat (3) tick();
        chk("mid_rst_nwr", 32'(n_wr - base_wr), 32'd1);
        chk("idle_ignore", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'd0);

        // Timeout mid-DATA after exactly 50 idle clocks
        start_load();
        send4(32'h0000_0001, 1'b0);
        send(8'hAA); send(8'hBB);
        repeat (49) tick();
        chk("to_49", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b1001);
        tick();
        chk("to_50", {28'd0, BUSY, DONE, ERR, CPU_RESET}, 32'b0011);
        chk("to_nwr", 32'(n_wr - base_wr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_prog_loader.md
OTTER_PROG_LOADER -- requirements
Module: otter_prog_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0 of the loaded image.
REQ-002 The block SHALL have parameter MAX_WORDS, default 16384, the largest accepted image length in words.
REQ-003 The block SHALL have parameter TIMEOUT, default 1_000_000, the maximum idle clocks between bytes mid-transfer.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous active-high reset.
- START  in  1  one-cycle pulse that begins a load.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  RX_DATA valid this cycle, one byte per high cycle.
- MEM_ADDR2  out  32  memory port-2 byte address.
- MEM_DIN2  out  32  memory port-2 write data.
- MEM_WRITE2  out  1  one-cycle word write strobe.
- MEM_SIZE2  out  2  access size, constant 2'b10 (word).
- CPU_RESET  out  1  holds the CPU in reset while loading.
- BUSY  out  1  load in progress.
- DONE  out  1  sticky: last load succeeded.
- ERR  out  1  sticky: last load failed.

Function
REQ-005 The FSM SHALL have the states IDLE, LEN, DATA, CHECK, FIN and FAIL.
REQ-006 In IDLE, FIN or FAIL, a START pulse SHALL move the FSM to LEN, clear DONE and ERR, and zero the byte, word and checksum counters.
REQ-007 START SHALL be ignored in LEN, DATA and CHECK.
REQ-008 In LEN, the FSM SHALL accept 4 bytes forming the 32-bit word count N, little-endian (first byte = N[7:0]).
REQ-009 After the 4th LEN byte, the FSM SHALL go to FAIL if N > MAX_WORDS, to CHECK if N == 0, and to DATA otherwise.
REQ-010 In DATA, the block SHALL assemble bytes little-endian into words and XOR every data byte into an 8-bit checksum register.
REQ-011 In the cycle after the 4th byte of word i is accepted, the block SHALL assert MEM_WRITE2 = 1 with MEM_ADDR2 = BASE_ADDR + 4*i and MEM_DIN2 = the assembled word, all three registered.
REQ-012 MEM_WRITE2 SHALL be high for exactly one cycle per word.
REQ-013 An RX_VALID byte arriving in the same cycle as a write strobe SHALL be accepted, never dropped or stalled.
REQ-014 MEM_ADDR2 arithmetic SHALL be modulo 2^32.
REQ-015 After word N-1 is assembled, the FSM SHALL go to CHECK.
REQ-016 In CHECK, the block SHALL accept one byte and go to FIN with DONE = 1 if the byte equals the checksum, otherwise to FAIL with ERR = 1.
REQ-017 Every word already written SHALL remain written regardless of the CHECK result; no rollback is performed.
REQ-018 In LEN, DATA and CHECK, an idle counter SHALL reset on each accepted byte and increment otherwise; reaching TIMEOUT SHALL move the FSM to FAIL with ERR = 1.
REQ-019 RX_VALID SHALL be ignored in IDLE, FIN and FAIL.
REQ-020 BUSY SHALL be 1 exactly in LEN, DATA and CHECK.
REQ-021 CPU_RESET SHALL be 1 in LEN, DATA, CHECK and FAIL, and 0 in IDLE and FIN, so that a failed image never runs.
REQ-022 BUSY, DONE, ERR, CPU_RESET and MEM_WRITE2 SHALL be registered outputs.

Reset
REQ-023 RESET SHALL take priority over all other inputs, including START and RX_VALID in the same cycle.
REQ-024 On RESET, the FSM SHALL enter IDLE and all counters and the checksum SHALL clear.
REQ-025 On RESET, the outputs SHALL take these values: MEM_WRITE2 = 0, MEM_ADDR2 = 0, MEM_DIN2 = 0, BUSY = 0, DONE = 0, ERR = 0, CPU_RESET = 0.
REQ-026 RESET asserted mid-load SHALL abort the load with no further writes; a strobe pending from the previous cycle SHALL NOT be issued.

Verification
REQ-027 The bench SHALL cover a nominal load: START; bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00, checksum 7C -> writes (0x0, 0x00000013) and (0x4, 0x0000006F), DONE = 1, CPU_RESET = 0.
REQ-028 The bench SHALL cover a bad checksum: the same stream with checksum 00 -> both words written, ERR = 1, CPU_RESET held at 1.
REQ-029 The bench SHALL cover an oversize length: bytes 01 40 00 00 (N = 16385) -> FAIL after the 4th byte, no MEM_WRITE2, ERR = 1.
REQ-030 The bench SHALL cover an empty image: bytes 00 00 00 00 then 00 -> zero writes, DONE = 1.
REQ-031 The bench SHALL cover a back-to-back stream: RX_VALID high every cycle -> every byte accepted, each strobe one cycle after its word completes, no drops.
REQ-032 The bench SHALL cover the timeout and reset cases:
- With TIMEOUT = 50, stop mid-DATA -> ERR = 1 after 50 idle clocks.
- RESET mid-DATA -> outputs return to their reset values, no further strobes.
